// File: rtl/nor_exec_pkg.sv
// Shared types, widths and gate evaluation for the NOR netlist executor.
// Default sizing: 32 wires, 8 primary inputs, 8 primary outputs, 64-entry program.
package nor_exec_pkg;

  localparam int NUM_WIRES  = 32;
  localparam int NUM_IN     = 8;
  localparam int NUM_OUT    = 8;
  localparam int PROG_DEPTH = 64;

  localparam int WIRE_W  = $clog2(NUM_WIRES);
  localparam int ADDR_W  = $clog2(PROG_DEPTH);
  localparam int LEN_W   = ADDR_W + 1;
  localparam int INSTR_W = 2 + 4 * WIRE_W;

  localparam logic [WIRE_W-1:0] FIRST_GATE_WIRE = WIRE_W'(NUM_IN);
  localparam logic [LEN_W-1:0]  MAX_LEN         = LEN_W'(PROG_DEPTH);
  localparam logic [LEN_W-1:0]  LEN_ZERO        = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE         = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    OP_BUF  = 2'd0,
    OP_INV  = 2'd1,
    OP_NOR2 = 2'd2,
    OP_NOR3 = 2'd3
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [WIRE_W-1:0] dst;
    logic [WIRE_W-1:0] src_a;
    logic [WIRE_W-1:0] src_b;
    logic [WIRE_W-1:0] src_c;
  } instr_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic eval_gate(input op_e op, input logic a, input logic b, input logic c);
    logic r;
    case (op)
      OP_BUF:  r = a;
      OP_INV:  r = ~a;
      OP_NOR2: r = ~(a | b);
      OP_NOR3: r = ~(a | b | c);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Lengths beyond the program store run the whole store
  function automatic logic [LEN_W-1:0] sat_len(input logic [LEN_W-1:0] len);
    return (len > MAX_LEN) ? MAX_LEN : len;
  endfunction

endpackage

// File: rtl/nor_exec_wire_file.sv
// One-bit-per-wire register file: three combinational read ports, one write port,
// and a bulk load that seeds the primary inputs and clears every other wire.
module nor_exec_wire_file
  import nor_exec_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [NUM_IN-1:0]   load_vec,
  input  logic                we,
  input  logic [WIRE_W-1:0]   waddr,
  input  logic                wdata,
  input  logic [WIRE_W-1:0]   raddr_a,
  input  logic [WIRE_W-1:0]   raddr_b,
  input  logic [WIRE_W-1:0]   raddr_c,
  output logic                rdata_a,
  output logic                rdata_b,
  output logic                rdata_c,
  output logic [NUM_OUT-1:0]  out_bits
);

  logic [NUM_WIRES-1:0] wires_r;

  // Wire storage: reset clear, per-transaction seed, single gate write
  always_ff @(posedge clk) begin
    if (rst) begin
      wires_r <= {NUM_WIRES{1'b0}};
    end else if (load) begin
      wires_r <= {{(NUM_WIRES-NUM_IN){1'b0}}, load_vec};
    end else if (we) begin
      wires_r[waddr] <= wdata;
    end else begin
      wires_r <= wires_r;
    end
  end

  assign rdata_a  = wires_r[raddr_a];
  assign rdata_b  = wires_r[raddr_b];
  assign rdata_c  = wires_r[raddr_c];
  assign out_bits = wires_r[NUM_WIRES-1 -: NUM_OUT];

endmodule

// File: rtl/nor_netlist_exec.sv
// Sequential executor for mapped buf/inv/nor2/nor3 netlists, one gate per cycle.
// Optional macro ILLEGAL_DST_CHECK_EN aborts a run whose gate targets a primary-input wire.
module nor_netlist_exec
  import nor_exec_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                prog_we,
  input  logic [ADDR_W-1:0]   prog_addr,
  input  logic [INSTR_W-1:0]  prog_wdata,
  input  logic [LEN_W-1:0]    prog_len,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NUM_IN-1:0]   in_vec,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [NUM_OUT-1:0]  out_vec,
  output logic                err
);

  instr_t           prog_mem_r [PROG_DEPTH];
  state_e           state_r, state_s;
  logic [LEN_W-1:0] pc_r, len_r, len_sat_s, pc_next_s;
  logic             in_ready_r, out_valid_r, err_r;
  instr_t           instr_s;
  logic             rd_a_s, rd_b_s, rd_c_s, gate_val_s;
  logic             load_s, wf_we_s, abort_s, release_s, illegal_s;

  assign instr_s    = prog_mem_r[pc_r[ADDR_W-1:0]];
  assign gate_val_s = eval_gate(instr_s.op, rd_a_s, rd_b_s, rd_c_s);
  assign len_sat_s  = sat_len(prog_len);
  assign pc_next_s  = pc_r + LEN_ONE;

`ifdef ILLEGAL_DST_CHECK_EN
  assign illegal_s = (instr_s.dst < FIRST_GATE_WIRE);
`else
  assign illegal_s = 1'b0;
`endif

  // Program store: writable only while idle so a run sees a frozen program
  always_ff @(posedge clk) begin
    if (prog_we && (state_r == ST_IDLE)) begin
      prog_mem_r[prog_addr] <= instr_t'(prog_wdata);
    end
  end

  nor_exec_wire_file u_wire_file (
    .clk      (clk),
    .rst      (rst),
    .load     (load_s),
    .load_vec (in_vec),
    .we       (wf_we_s),
    .waddr    (instr_s.dst),
    .wdata    (gate_val_s),
    .raddr_a  (instr_s.src_a),
    .raddr_b  (instr_s.src_b),
    .raddr_c  (instr_s.src_c),
    .rdata_a  (rd_a_s),
    .rdata_b  (rd_b_s),
    .rdata_c  (rd_c_s),
    .out_bits (out_vec)
  );

  // Next-state decode and datapath strobes
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    wf_we_s   = 1'b0;
    abort_s   = 1'b0;
    release_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (in_valid) begin
          load_s = 1'b1;
          if (len_sat_s == LEN_ZERO) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_EXEC;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EXEC: begin
        if (illegal_s) begin
          abort_s = 1'b1;
          state_s = ST_DONE;
        end else begin
          wf_we_s = 1'b1;
          if (pc_next_s == len_r) begin
            state_s = ST_DONE;
          end else begin
            state_s = ST_EXEC;
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          release_s = 1'b1;
          state_s   = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State, program counter and registered handshake/error outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      pc_r        <= LEN_ZERO;
      len_r       <= LEN_ZERO;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      state_r     <= state_s;
      in_ready_r  <= (state_s == ST_IDLE);
      out_valid_r <= (state_s == ST_DONE);
      if (load_s) begin
        pc_r  <= LEN_ZERO;
        len_r <= len_sat_s;
      end else if (wf_we_s) begin
        pc_r  <= pc_next_s;
        len_r <= len_r;
      end else begin
        pc_r  <= pc_r;
        len_r <= len_r;
      end
      if (abort_s) begin
        err_r <= 1'b1;
      end else if (release_s) begin
        err_r <= 1'b0;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign err       = err_r;

endmodule

// File: tb/tb_nor_netlist_exec.sv
// Self-checking bench for nor_netlist_exec: directed table, hand sequences for
// multi-cycle corners, and random programs checked against a wire-array model.
module tb_nor_netlist_exec;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_we;
  logic [5:0]  prog_addr;
  logic [21:0] prog_wdata;
  logic [6:0]  prog_len;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_vec;
  logic        err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [21:0] prog_q [64];

  typedef struct {
    logic [7:0] vin;
    logic [6:0] len;
    logic [7:0] exp_out;
    int         exp_lat;
    int         hold;
  } vec_t;
  vec_t vt [3];

  nor_netlist_exec dut (
    .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_wdata(prog_wdata), .prog_len(prog_len), .in_valid(in_valid),
    .in_ready(in_ready), .in_vec(in_vec), .out_valid(out_valid),
    .out_ready(out_ready), .out_vec(out_vec), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [21:0] mk(input int op, input int d, input int a, input int b, input int c);
    return {op[1:0], d[4:0], a[4:0], b[4:0], c[4:0]};
  endfunction

  // Reference: evaluate the gate list over a plain array of wire values
  function automatic void model_run(input logic [7:0] v, input int len,
                                    output logic [7:0] o, output int lat, output logic e);
    logic w [32];
    int n;
    n = (len > 64) ? 64 : len;
    for (int i = 0; i < 32; i++) w[i] = (i < 8) ? v[i] : 1'b0;
    e   = 1'b0;
    lat = n + 1;
    for (int i = 0; i < n; i++) begin
      logic [21:0] ins;
      int op, d, a, b, c;
      logic r;
      ins = prog_q[i];
      op = int'(ins[21:20]); d = int'(ins[19:15]);
      a = int'(ins[14:10]);  b = int'(ins[9:5]); c = int'(ins[4:0]);
      case (op)
        0:       r = w[a];
        1:       r = ~w[a];
        2:       r = ~(w[a] | w[b]);
        default: r = ~(w[a] | w[b] | w[c]);
      endcase
`ifdef ILLEGAL_DST_CHECK_EN
      if (d < 8) begin
        e   = 1'b1;
        lat = i + 2;
        break;
      end
`endif
      w[d] = r;
    end
    for (int i = 0; i < 8; i++) o[i] = w[24 + i];
  endfunction

  task automatic write_instr(input int addr, input logic [21:0] data);
    @(negedge clk);
    prog_we    = 1'b1;
    prog_addr  = addr[5:0];
    prog_wdata = data;
    prog_q[addr] = data;
    @(posedge clk);
    #1 prog_we = 1'b0;
  endtask

  function automatic logic [21:0] rand_instr(input bit allow_low);
    int d;
    if (allow_low && ($urandom_range(0, 7) == 0)) d = $urandom_range(0, 7);
    else d = $urandom_range(8, 31);
    return mk($urandom_range(0, 3), d, $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 31));
  endfunction

  task automatic start(input logic [7:0] v, input logic [6:0] len, output int t0);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL start_timeout in_ready=0 required=1");
    end
    in_valid = 1'b1;
    in_vec   = v;
    prog_len = len;
    t0       = cyc;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic finish(input string name, input logic [7:0] exp_out, input int exp_lat,
                        input logic exp_err, input int hold, input int t0);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    check({name, "_valid"}, out_valid, 1);
    check({name, "_lat"}, cyc - t0, exp_lat);
    check({name, "_out"}, out_vec, exp_out);
    check({name, "_err"}, err, exp_err);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_out"}, out_vec, exp_out);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({name, "_rdy_after"}, in_ready, 1);
    check({name, "_vld_after"}, out_valid, 0);
    check({name, "_err_after"}, err, 0);
  endtask

  task automatic run_model(input string name, input logic [7:0] v, input logic [6:0] len);
    logic [7:0] o;
    int lat, t0;
    logic e;
    model_run(v, int'(len), o, lat, e);
    start(v, len, t0);
    finish(name, o, lat, e, 0, t0);
  endtask

  initial begin
    int t0;
    logic [7:0] o;
    int lat;
    logic e;

    rst = 1'b1; prog_we = 1'b0; prog_addr = 6'd0; prog_wdata = 22'd0; prog_len = 7'd0;
    in_valid = 1'b0; in_vec = 8'd0; out_ready = 1'b0;
    for (int i = 0; i < 64; i++) prog_q[i] = 22'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_vec", out_vec, 0);
    check("reset_err", err, 0);

    // b1: d=a^b (w24), e=~b (w25), f=~(a^b) (w26), g=b&~c (w27), w28=a|b|c
    write_instr(0,  mk(2, 8, 0, 1, 0));
    write_instr(1,  mk(2, 9, 0, 8, 0));
    write_instr(2,  mk(2, 10, 1, 8, 0));
    write_instr(3,  mk(2, 11, 9, 10, 0));
    write_instr(4,  mk(1, 24, 11, 0, 0));
    write_instr(5,  mk(0, 26, 11, 0, 0));
    write_instr(6,  mk(1, 25, 1, 0, 0));
    write_instr(7,  mk(2, 27, 25, 2, 0));
    write_instr(8,  mk(3, 13, 0, 1, 2));
    write_instr(9,  mk(1, 14, 13, 0, 0));
    write_instr(10, mk(0, 28, 14, 0, 0));

    vt[0] = '{vin: 8'h05, len: 7'd11, exp_out: 8'h13, exp_lat: 12, hold: 0};
    vt[1] = '{vin: 8'h03, len: 7'd11, exp_out: 8'h1C, exp_lat: 12, hold: 0};
    vt[2] = '{vin: 8'hA5, len: 7'd0,  exp_out: 8'h00, exp_lat: 1,  hold: 5};
    for (int i = 0; i < 3; i++) begin
      start(vt[i].vin, vt[i].len, t0);
      finish($sformatf("table%0d", i), vt[i].exp_out, vt[i].exp_lat, 1'b0, vt[i].hold, t0);
    end

    for (int v = 0; v < 8; v++) begin
      logic [7:0] vin;
      vin = {5'($urandom_range(0, 31)), 3'(v)};
      run_model($sformatf("b1_sweep%0d", v), vin, 7'd11);
    end

    // Program writes during a run are dropped
    model_run(8'h05, 11, o, lat, e);
    start(8'h05, 7'd11, t0);
    @(negedge clk);
    prog_we = 1'b1; prog_addr = 6'd3; prog_wdata = mk(3, 24, 0, 0, 0);
    @(posedge clk);
    #1 prog_we = 1'b0;
    finish("we_in_exec", o, lat, e, 0, t0);
    run_model("we_in_exec_next", 8'h03, 7'd11);

    // Reset three cycles into a run
    start(8'h05, 7'd11, t0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_out_vec", out_vec, 0);
    check("midrst_err", err, 0);
    start(8'h05, 7'd11, t0);
    finish("midrst_rerun", 8'h13, 12, 1'b0, 0, t0);

    // Gate 2 writes primary input wire 0; gate 3 copies wire 0 to out bit 0
    write_instr(0, mk(0, 25, 0, 0, 0));
    write_instr(1, mk(0, 0, 1, 0, 0));
    write_instr(2, mk(0, 24, 0, 0, 0));
    start(8'h01, 7'd3, t0);
`ifdef ILLEGAL_DST_CHECK_EN
    finish("illegal_dst", 8'h02, 3, 1'b1, 0, t0);
`else
    finish("illegal_dst", 8'h02, 4, 1'b0, 0, t0);
`endif

    for (int p = 0; p < 5; p++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int i = 0; i < len; i++) write_instr(i, rand_instr(1'b1));
      for (int k = 0; k < 3; k++)
        run_model($sformatf("rand_p%0d_v%0d", p, k), 8'($urandom_range(0, 255)), 7'(len));
    end

    for (int i = 0; i < 64; i++) write_instr(i, rand_instr(1'b0));
    run_model("len_sat100", 8'($urandom_range(0, 255)), 7'd100);
    run_model("len_full64", 8'($urandom_range(0, 255)), 7'd64);
    run_model("len_63", 8'($urandom_range(0, 255)), 7'd63);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit expired");
    $fatal(1, "watchdog");
  end

endmodule
